// File: rtl/rmt_pkg.sv
// rmt_pkg: shared state, header offsets and rule entry type for the RMT match table
package rmt_pkg;
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
    localparam int ETH_TYPE_OFF = 12;
    localparam int DELIM_OFF = 42;
    localparam int FUNC_OFF = 44;
    localparam int RULE_DEST_MAX = 8;
    typedef struct packed {
        logic valid;
        logic [15:0] func;
        logic drop;
        logic [RULE_DEST_MAX-1:0] dest;
    } rule_t;
endpackage

// File: rtl/rmt_rule_lookup.sv
// rmt_rule_lookup: programmable rule table with lowest-index-wins func_type match
module rmt_rule_lookup
    import rmt_pkg::*;
#(
    parameter int RULE_COUNT = 4,
    parameter int DEST_WIDTH = 2,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic                  wr_valid,
    input  logic [15:0]           wr_func,
    input  logic                  wr_drop,
    input  logic [DEST_WIDTH-1:0] wr_dest,
    input  logic [15:0]           key,
    output logic                  hit,
    output logic                  drop,
    output logic [DEST_WIDTH-1:0] dest
);
    rule_t rules [RULE_COUNT];

    // addresses beyond RULE_COUNT match no entry and are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RULE_COUNT; i++) rules[i] <= '0;
        end else begin
            for (int i = 0; i < RULE_COUNT; i++)
                if (wr_en && wr_addr == ADDR_WIDTH'(i))
                    rules[i] <= '{valid: wr_valid, func: wr_func, drop: wr_drop, dest: RULE_DEST_MAX'(wr_dest)};
        end
    end

    always_comb begin
        hit = 1'b0;
        drop = 1'b0;
        dest = '0;
        for (int i = RULE_COUNT - 1; i >= 0; i--)
            if (rules[i].valid && rules[i].func == key) begin
                hit = 1'b1;
                drop = rules[i].drop;
                dest = DEST_WIDTH'(rules[i].dest);
            end
    end
endmodule

// File: rtl/rmt_match_table.sv
// rmt_match_table: classifies AXI-Stream frames on their header beat and forwards or drops them whole
module rmt_match_table
    import rmt_pkg::*;
#(
    parameter int          DATA_WIDTH      = 512,
    parameter int          KEEP_WIDTH      = DATA_WIDTH / 8,
    parameter int          USER_WIDTH      = 1,
    parameter int          DEST_WIDTH      = 2,
    parameter int          RULE_COUNT      = 4,
    parameter logic [15:0] ETHERTYPE_MATCH = 16'h0008,
    parameter logic [15:0] DELIM_MATCH     = 16'hF0E1,
    parameter int          CNT_WIDTH       = 32,
    localparam int         ADDR_WIDTH      = RULE_COUNT > 1 ? $clog2(RULE_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    input  logic                  cfg_wr_en,
    input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
    input  logic                  cfg_wr_valid,
    input  logic [15:0]           cfg_wr_func,
    input  logic                  cfg_wr_drop,
    input  logic [DEST_WIDTH-1:0] cfg_wr_dest,
    input  logic                  cfg_miss_drop,
    input  logic [DEST_WIDTH-1:0] cfg_miss_dest,
    input  logic                  cfg_nonrmt_drop,
    output logic [CNT_WIDTH-1:0]  stat_fwd_count,
    output logic [CNT_WIDTH-1:0]  stat_drop_count,
    output logic [CNT_WIDTH-1:0]  stat_miss_count
);
    state_t state, state_nxt;
    logic hit, rule_drop, is_rmt, hdr_drop, cur_drop, acc, hdr;
    logic [DEST_WIDTH-1:0] rule_dest, hdr_dest, cur_dest, dest_q;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
        return c + CNT_WIDTH'(en && c != '1);
    endfunction

    rmt_rule_lookup #(.RULE_COUNT(RULE_COUNT), .DEST_WIDTH(DEST_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lookup (
        .clk(clk), .rst_n(rst_n), .wr_en(cfg_wr_en), .wr_addr(cfg_wr_addr), .wr_valid(cfg_wr_valid),
        .wr_func(cfg_wr_func), .wr_drop(cfg_wr_drop), .wr_dest(cfg_wr_dest),
        .key(s_axis_tdata[FUNC_OFF*8 +: 16]), .hit(hit), .drop(rule_drop), .dest(rule_dest)
    );

    assign is_rmt = s_axis_tdata[ETH_TYPE_OFF*8 +: 16] == ETHERTYPE_MATCH &&
                    s_axis_tdata[DELIM_OFF*8 +: 16] == DELIM_MATCH && s_axis_tkeep[FUNC_OFF+1];
    assign hdr_drop = is_rmt ? (hit ? rule_drop : cfg_miss_drop) : cfg_nonrmt_drop;
    assign hdr_dest = !is_rmt ? '0 : hit ? rule_dest : cfg_miss_dest;
    assign s_axis_tready = rst_n && (state == DROP || !m_axis_tvalid || m_axis_tready);
    assign acc = s_axis_tvalid && s_axis_tready;
    assign hdr = acc && state == IDLE;
    assign cur_drop = state == IDLE ? hdr_drop : state == DROP;
    assign cur_dest = state == IDLE ? hdr_dest : dest_q;

    always_comb begin
        state_nxt = state;
        if (acc)
            state_nxt = s_axis_tlast ? IDLE : state == IDLE ? (hdr_drop ? DROP : FWD) : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            dest_q <= '0;
        end else begin
            state <= state_nxt;
            if (hdr) dest_q <= hdr_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axis_tdata <= '0;
            m_axis_tkeep <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast <= 1'b0;
            m_axis_tuser <= '0;
            m_axis_tdest <= '0;
        end else if (acc && !cur_drop) begin
            m_axis_tdata <= s_axis_tdata;
            m_axis_tkeep <= s_axis_tkeep;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast <= s_axis_tlast;
            m_axis_tuser <= s_axis_tuser;
            m_axis_tdest <= cur_dest;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fwd_count <= '0;
            stat_drop_count <= '0;
            stat_miss_count <= '0;
        end else if (hdr) begin
            stat_fwd_count <= sat_inc(stat_fwd_count, !hdr_drop);
            stat_drop_count <= sat_inc(stat_drop_count, hdr_drop);
            stat_miss_count <= sat_inc(stat_miss_count, is_rmt && !hit);
        end
    end
endmodule

// File: tb/tb_rmt_match_table.sv
// tb_rmt_match_table: randomized frames against a frame-level classification model
module tb_rmt_match_table;
    localparam int DW = 512, KW = DW / 8, UW = 1, DSW = 2, RC = 4, CW = 32;
    localparam logic [15:0] ETH = 16'h0008, DELIM = 16'hF0E1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0, m_axis_tdata;
    logic [KW-1:0] s_axis_tkeep = '0, m_axis_tkeep;
    logic s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
    logic [UW-1:0] s_axis_tuser = '0, m_axis_tuser;
    logic m_axis_tvalid, m_axis_tready = 1'b1, m_axis_tlast;
    logic [DSW-1:0] m_axis_tdest;
    logic cfg_wr_en = 1'b0, cfg_wr_valid = 1'b0, cfg_wr_drop = 1'b0;
    logic [1:0] cfg_wr_addr = '0;
    logic [15:0] cfg_wr_func = '0;
    logic [DSW-1:0] cfg_wr_dest = '0, cfg_miss_dest = '0;
    logic cfg_miss_drop = 1'b0, cfg_nonrmt_drop = 1'b0;
    logic [CW-1:0] stat_fwd_count, stat_drop_count, stat_miss_count;

    always #5 clk = ~clk;

    rmt_match_table #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEST_WIDTH(DSW), .RULE_COUNT(RC),
                      .ETHERTYPE_MATCH(ETH), .DELIM_MATCH(DELIM), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tdest(m_axis_tdest),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_valid(cfg_wr_valid),
        .cfg_wr_func(cfg_wr_func), .cfg_wr_drop(cfg_wr_drop), .cfg_wr_dest(cfg_wr_dest),
        .cfg_miss_drop(cfg_miss_drop), .cfg_miss_dest(cfg_miss_dest), .cfg_nonrmt_drop(cfg_nonrmt_drop),
        .stat_fwd_count(stat_fwd_count), .stat_drop_count(stat_drop_count), .stat_miss_count(stat_miss_count)
    );

    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic l;
        logic [UW-1:0] u;
        logic [DSW-1:0] t;
    } beat_t;

    beat_t exp_q[$];
    logic tv[RC];
    logic [15:0] tf[RC];
    logic tdr[RC];
    logic [DSW-1:0] tds[RC];
    logic [CW-1:0] n_fwd = '0, n_drop = '0, n_miss = '0;
    int fwd_in = 0, out_n = 0, checks = 0, errors = 0, rdy_mode = 1;
    bit mon_en = 0, in_drop = 0, tog = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // output side: choose tready each cycle and score every beat handed over at the next edge
    always @(negedge clk) if (mon_en) begin
        logic full;
        beat_t b;
        full = fwd_in != out_n;
        check("m_tvalid", DW'(m_axis_tvalid), DW'(full));
        tog = !tog;
        m_axis_tready = rdy_mode == 1 ? 1'b1 : rdy_mode == 2 ? tog : 1'($urandom);
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) check("spurious beat", DW'(1), DW'(0));
            else begin
                b = exp_q.pop_front();
                check("tdata", m_axis_tdata, b.d);
                check("tkeep", DW'(m_axis_tkeep), DW'(b.k));
                check("tlast", DW'(m_axis_tlast), DW'(b.l));
                check("tuser", DW'(m_axis_tuser), DW'(b.u));
                check("tdest", DW'(m_axis_tdest), DW'(b.t));
            end
            out_n++;
        end
        #1 check("s_tready", DW'(s_axis_tready), DW'(in_drop || !full || m_axis_tready));
    end

    task automatic send_beat(input beat_t b, input bit fwd, input bit gaps);
        @(negedge clk);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        s_axis_tdata = b.d;
        s_axis_tkeep = b.k;
        s_axis_tlast = b.l;
        s_axis_tuser = b.u;
        s_axis_tvalid = 1'b1;
        for (int n = 0; ; n++) begin
            #2;
            if (s_axis_tready) break;
            if (n > 500) begin
                $display("FAIL s_tready stuck low");
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        if (fwd) fwd_in++;
        #1 s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input int nb, input logic [15:0] eth, input logic [15:0] delim,
                              input logic [15:0] func, input bit k45, input bit gaps);
        bit rmt, hit, drop;
        logic [DSW-1:0] dest;
        beat_t b;
        rmt = eth == ETH && delim == DELIM && k45;
        hit = 0;
        drop = rmt ? cfg_miss_drop : cfg_nonrmt_drop;
        dest = rmt ? cfg_miss_dest : '0;
        for (int i = 0; i < RC; i++)
            if (rmt && !hit && tv[i] && tf[i] == func) begin
                hit = 1;
                drop = tdr[i];
                dest = tds[i];
            end
        if (drop) n_drop = n_drop == '1 ? n_drop : n_drop + 1;
        else n_fwd = n_fwd == '1 ? n_fwd : n_fwd + 1;
        if (rmt && !hit) n_miss = n_miss == '1 ? n_miss : n_miss + 1;
        for (int j = 0; j < nb; j++) begin
            for (int w = 0; w < DW / 32; w++) b.d[w*32 +: 32] = $urandom;
            b.k = '1;
            b.l = j == nb - 1;
            b.u = UW'($urandom);
            b.t = dest;
            if (j == 0) begin
                b.d[96 +: 16] = eth;
                b.d[336 +: 16] = delim;
                b.d[352 +: 16] = func;
                b.k[45] = k45;
            end
            if (!drop) exp_q.push_back(b);
            send_beat(b, !drop, gaps);
            in_drop = drop && !b.l;
        end
    endtask

    task automatic cfg_write(input int a, input bit v, input logic [15:0] f, input bit d, input logic [DSW-1:0] t);
        @(negedge clk);
        cfg_wr_en = 1'b1;
        cfg_wr_addr = 2'(a);
        cfg_wr_valid = v;
        cfg_wr_func = f;
        cfg_wr_drop = d;
        cfg_wr_dest = t;
        @(posedge clk);
        #1 cfg_wr_en = 1'b0;
        tv[a] = v;
        tf[a] = f;
        tdr[a] = d;
        tds[a] = t;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || fwd_in != out_n) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain", DW'(exp_q.size()), DW'(0));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_counters(input string tag);
        check({tag, " fwd_count"}, DW'(stat_fwd_count), DW'(n_fwd));
        check({tag, " drop_count"}, DW'(stat_drop_count), DW'(n_drop));
        check({tag, " miss_count"}, DW'(stat_miss_count), DW'(n_miss));
    endtask

    task automatic clear_model();
        for (int i = 0; i < RC; i++) begin
            tv[i] = 0; tf[i] = '0; tdr[i] = 0; tds[i] = '0;
        end
        n_fwd = '0; n_drop = '0; n_miss = '0;
        exp_q.delete();
        fwd_in = 0; out_n = 0; in_drop = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        beat_t hb;
        clear_model();
        #3;
        check("reset m_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("reset s_tready", DW'(s_axis_tready), DW'(0));
        check_counters("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #2 mon_en = 1;

        cfg_write(0, 1, 16'h0001, 0, 2'b01);
        send_frame(3, ETH, DELIM, 16'h0001, 1, 0);
        drain();
        check_counters("fwd rule0");

        cfg_write(1, 1, 16'h0002, 1, 2'b00);
        send_frame(4, ETH, DELIM, 16'h0002, 1, 0);
        send_frame(3, ETH, DELIM, 16'h0001, 1, 0);
        drain();
        check_counters("drop rule1");

        cfg_write(0, 1, 16'h0003, 0, 2'b01);
        cfg_write(2, 1, 16'h0003, 0, 2'b10);
        send_frame(2, ETH, DELIM, 16'h0003, 1, 0);
        drain();
        check_counters("priority");

        cfg_miss_drop = 0;
        cfg_miss_dest = 2'b11;
        send_frame(2, ETH, DELIM, 16'h0009, 1, 0);
        cfg_nonrmt_drop = 1;
        send_frame(3, 16'h0608, DELIM, 16'h0003, 1, 0);
        cfg_nonrmt_drop = 0;
        send_frame(1, ETH, DELIM, 16'h0003, 0, 0);
        drain();
        check_counters("miss/nonrmt");

        rdy_mode = 2;
        send_frame(5, ETH, DELIM, 16'h0003, 1, 0);
        drain();
        check_counters("toggle");

        rdy_mode = 0;
        for (int f = 0; f < 60; f++) begin
            if ($urandom_range(0, 2) == 0)
                cfg_write($urandom_range(0, RC - 1), 1'($urandom), 16'($urandom_range(0, 5)), 1'($urandom), DSW'($urandom));
            cfg_miss_drop = 1'($urandom);
            cfg_miss_dest = DSW'($urandom);
            cfg_nonrmt_drop = 1'($urandom);
            send_frame($urandom_range(1, 4), $urandom_range(0, 4) == 0 ? 16'h0608 : ETH,
                       $urandom_range(0, 4) == 0 ? 16'h1234 : DELIM, 16'($urandom_range(0, 5)),
                       $urandom_range(0, 5) != 0, 1);
        end
        drain();
        check_counters("random");

        rdy_mode = 1;
        mon_en = 0;
        m_axis_tready = 1'b1;
        cfg_write(3, 1, 16'h0001, 0, 2'b01);
        cfg_nonrmt_drop = 0;
        for (int j = 0; j < 2; j++) begin
            for (int w = 0; w < DW / 32; w++) hb.d[w*32 +: 32] = $urandom;
            hb.d[96 +: 16] = ETH;
            hb.d[336 +: 16] = DELIM;
            hb.d[352 +: 16] = 16'h0001;
            hb.k = '1;
            hb.l = 0;
            hb.u = '0;
            hb.t = '0;
            send_beat(hb, 0, 0);
        end
        #2 rst_n = 1'b0;
        #1;
        check("midreset m_tvalid", DW'(m_axis_tvalid), DW'(0));
        check("midreset m_tdata", m_axis_tdata, DW'(0));
        check("midreset m_tdest", DW'(m_axis_tdest), DW'(0));
        check("midreset m_tlast", DW'(m_axis_tlast), DW'(0));
        check("midreset s_tready", DW'(s_axis_tready), DW'(0));
        clear_model();
        check_counters("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2 mon_en = 1;
        cfg_miss_drop = 0;
        cfg_miss_dest = 2'b10;
        send_frame(3, ETH, DELIM, 16'h0001, 1, 0);
        drain();
        check_counters("after reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
